writeback_queue: RTL and testbench

- Writeback stage sitting directly upstream of the register bank. It accepts completed results from the ALU and the memory unit through valid/ready handshakes.
- Results are buffered in a small in-order queue, and at most one entry per cycle is drained into the register bank's single write port.
- Queued but not yet written results are forwarded to the operand-read path, so consumers never see stale register values.

---
 rtl/writeback_queue_if.sv | 61 ++++++
 rtl/writeback_queue.sv | 104 ++++++++++
 tb/tb_writeback_queue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// Writeback queue bundle: ALU/memory result handshakes, regbank write port,
// operand forwarding lookups and occupancy.
interface writeback_queue_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned REG_SEL = 5,
   parameter int unsigned DEPTH   = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic               alu_valid;
   logic               alu_ready;
   logic [REG_SEL-1:0] alu_addr;
   logic               alu_sel;
   logic [WIDTH-1:0]   alu_data;

   logic               mem_valid;
   logic               mem_ready;
   logic [REG_SEL-1:0] mem_addr;
   logic               mem_sel;
   logic [WIDTH-1:0]   mem_data;

   logic               wb_stall;
   logic               write_enable;
   logic [REG_SEL-1:0] z_regbank_addr;
   logic               z_regbank_sel;
   logic [WIDTH-1:0]   z_data;

   logic [REG_SEL-1:0] a_regbank_addr;
   logic               a_regbank_sel;
   logic               fwd_a_hit;
   logic [WIDTH-1:0]   fwd_a_data;

   logic [REG_SEL-1:0] b_regbank_addr;
   logic               b_regbank_sel;
   logic               fwd_b_hit;
   logic [WIDTH-1:0]   fwd_b_data;

   logic [CNT_W-1:0]   count;

   modport slave (
      input  alu_valid, alu_addr, alu_sel, alu_data,
      input  mem_valid, mem_addr, mem_sel, mem_data,
      input  wb_stall,
      input  a_regbank_addr, a_regbank_sel, b_regbank_addr, b_regbank_sel,
      output alu_ready, mem_ready,
      output write_enable, z_regbank_addr, z_regbank_sel, z_data,
      output fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data,
      output count
   );

   modport master (
      output alu_valid, alu_addr, alu_sel, alu_data,
      output mem_valid, mem_addr, mem_sel, mem_data,
      output wb_stall,
      output a_regbank_addr, a_regbank_sel, b_regbank_addr, b_regbank_sel,
      input  alu_ready, mem_ready,
      input  write_enable, z_regbank_addr, z_regbank_sel, z_data,
      input  fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data,
      input  count
   );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback queue between the ALU/memory units and the register bank.
// Drains one entry per cycle and forwards pending results to operand reads.
module writeback_queue #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned REG_SEL      = 5,
   parameter int unsigned PRED_REG_SEL = 3,
   parameter int unsigned DEPTH        = 4
) (
   input logic               clk,
   input logic               reset,
   writeback_queue_if.slave  wb
);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam logic        S_REGS = 1'b0;
   localparam logic        P_REGS = 1'b1;

   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   alu_slot;
   logic               mem_push, alu_push, drain;

   logic [REG_SEL-1:0] addr_q [DEPTH];
   logic               sel_q  [DEPTH];
   logic [WIDTH-1:0]   data_q [DEPTH];

   // Readiness uses the registered count only; memory results take priority.
   assign wb.mem_ready = (count_q < CNT_W'(DEPTH));
   assign wb.alu_ready = (count_q <= CNT_W'(DEPTH - 2)) ||
                         ((count_q == CNT_W'(DEPTH - 1)) && !wb.mem_valid);

   assign mem_push = wb.mem_valid && wb.mem_ready;
   assign alu_push = wb.alu_valid && wb.alu_ready;
   assign drain    = (count_q != '0) && !wb.wb_stall;

   assign wb.write_enable   = drain;
   assign wb.z_regbank_addr = addr_q[head_q];
   assign wb.z_regbank_sel  = sel_q[head_q];
   assign wb.z_data         = data_q[head_q];
   assign wb.count          = count_q;

   always_comb begin
      alu_slot = tail_q + PTR_W'(mem_push);
      tail_d   = tail_q + PTR_W'(mem_push) + PTR_W'(alu_push);
      head_d   = head_q + PTR_W'(drain);
      count_d  = count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(drain);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry payloads are not reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (mem_push) begin
         addr_q[tail_q] <= wb.mem_addr;
         sel_q[tail_q]  <= wb.mem_sel;
         data_q[tail_q] <= wb.mem_data;
      end
      if (alu_push) begin
         addr_q[alu_slot] <= wb.alu_addr;
         sel_q[alu_slot]  <= wb.alu_sel;
         data_q[alu_slot] <= wb.alu_data;
      end
   end

   // Walk occupied entries oldest to youngest so the youngest match wins.
   function automatic logic [WIDTH:0] lookup(input logic [REG_SEL-1:0] addr,
                                             input logic               sel);
      logic [PTR_W-1:0] idx;
      logic             match;
      logic             hit;
      logic [WIDTH-1:0] data;
      hit  = 1'b0;
      data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (sel == P_REGS) begin
            match = (addr_q[idx][PRED_REG_SEL-1:0] == addr[PRED_REG_SEL-1:0]);
         end else begin
            match = (addr_q[idx] == addr);
         end
         if ((CNT_W'(i) < count_q) && (sel_q[idx] == sel) && match) begin
            hit  = 1'b1;
            data = (sel == S_REGS) ? data_q[idx] : {{(WIDTH-1){1'b0}}, data_q[idx][0]};
         end
      end
      return {hit, data};
   endfunction

   always_comb begin
      {wb.fwd_a_hit, wb.fwd_a_data} = lookup(wb.a_regbank_addr, wb.a_regbank_sel);
      {wb.fwd_b_hit, wb.fwd_b_data} = lookup(wb.b_regbank_addr, wb.b_regbank_sel);
   end
endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: stimulus pushes accepted results,
// a negedge monitor pops them against regbank writes and checks forwarding.
module tb_writeback_queue;
   localparam int unsigned WIDTH        = 32;
   localparam int unsigned REG_SEL      = 5;
   localparam int unsigned PRED_REG_SEL = 3;
   localparam int unsigned DEPTH        = 4;

   typedef struct packed {
      logic [REG_SEL-1:0] addr;
      logic               sel;
      logic [WIDTH-1:0]   data;
   } entry_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   writeback_queue_if #(.WIDTH(WIDTH), .REG_SEL(REG_SEL), .DEPTH(DEPTH)) wb ();

   writeback_queue #(
      .WIDTH(WIDTH), .REG_SEL(REG_SEL), .PRED_REG_SEL(PRED_REG_SEL), .DEPTH(DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb)
   );

   always #5 clk = ~clk;

   entry_t           sb[$];
   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] dut_regs_s [32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference forwarding: youngest pending result for that register.
   function automatic logic [WIDTH:0] model_fwd(input logic [REG_SEL-1:0] addr,
                                                input logic sel);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].sel == sel) begin
            if (sel && sb[i].addr[PRED_REG_SEL-1:0] == addr[PRED_REG_SEL-1:0])
               return {1'b1, {(WIDTH-1){1'b0}}, sb[i].data[0]};
            if (!sel && sb[i].addr == addr)
               return {1'b1, sb[i].data};
         end
      end
      return '0;
   endfunction

   // Monitor: compares the cycle's outputs with the model and retires writes.
   always @(negedge clk) begin : monitor
      int               n;
      logic             exp_we;
      logic [WIDTH:0]   fa, fb;
      entry_t           e;
      n      = sb.size();
      exp_we = (n != 0) && !wb.wb_stall;
      chk("count", 64'(wb.count), 64'(n));
      chk("mem_ready", 64'(wb.mem_ready), 64'(n < int'(DEPTH)));
      chk("alu_ready", 64'(wb.alu_ready),
          64'((n <= int'(DEPTH) - 2) || (n == int'(DEPTH) - 1 && !wb.mem_valid)));
      chk("write_enable", 64'(wb.write_enable), 64'(exp_we));
      fa = model_fwd(wb.a_regbank_addr, wb.a_regbank_sel);
      fb = model_fwd(wb.b_regbank_addr, wb.b_regbank_sel);
      chk("fwd_a_hit", 64'(wb.fwd_a_hit), 64'(fa[WIDTH]));
      chk("fwd_a_data", 64'(wb.fwd_a_data), 64'(fa[WIDTH-1:0]));
      chk("fwd_b_hit", 64'(wb.fwd_b_hit), 64'(fb[WIDTH]));
      chk("fwd_b_data", 64'(wb.fwd_b_data), 64'(fb[WIDTH-1:0]));
      if (wb.write_enable && !wb.z_regbank_sel) dut_regs_s[wb.z_regbank_addr] = wb.z_data;
      if (exp_we) begin
         e = sb.pop_front();
         chk("z_addr", 64'(wb.z_regbank_addr), 64'(e.addr));
         chk("z_sel", 64'(wb.z_regbank_sel), 64'(e.sel));
         chk("z_data", 64'(wb.z_data), 64'(e.data));
      end
   end

   // One cycle: drive at posedge+1, record acceptances after the monitor's negedge.
   task automatic step(input logic mv, input logic [REG_SEL-1:0] ma, input logic ms,
                       input logic [WIDTH-1:0] md, input logic av,
                       input logic [REG_SEL-1:0] aa, input logic as_,
                       input logic [WIDTH-1:0] ad, input logic stall);
      int   n;
      logic acc_m, acc_a;
      @(posedge clk);
      #1;
      wb.mem_valid = mv; wb.mem_addr = ma; wb.mem_sel = ms; wb.mem_data = md;
      wb.alu_valid = av; wb.alu_addr = aa; wb.alu_sel = as_; wb.alu_data = ad;
      wb.wb_stall  = stall;
      n     = sb.size();
      acc_m = mv && (n < int'(DEPTH));
      acc_a = av && ((n <= int'(DEPTH) - 2) || (n == int'(DEPTH) - 1 && !mv));
      #6;
      if (acc_m) sb.push_back(entry_t'{addr: ma, sel: ms, data: md});
      if (acc_a) sb.push_back(entry_t'{addr: aa, sel: as_, data: ad});
   endtask

   task automatic idle(input logic stall);
      step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, stall);
   endtask

   task automatic alu(input logic [REG_SEL-1:0] a, input logic s, input logic [WIDTH-1:0] d,
                      input logic stall);
      step(1'b0, '0, 1'b0, '0, 1'b1, a, s, d, stall);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) dut_regs_s[i] = '0;
      wb.mem_valid = 0; wb.mem_addr = '0; wb.mem_sel = 0; wb.mem_data = '0;
      wb.alu_valid = 0; wb.alu_addr = '0; wb.alu_sel = 0; wb.alu_data = '0;
      wb.wb_stall = 0;
      wb.a_regbank_addr = '0; wb.a_regbank_sel = 0;
      wb.b_regbank_addr = '0; wb.b_regbank_sel = 0;
      #12 reset = 1'b1;
      #1;
      chk("rst_count", 64'(wb.count), 64'(0));
      chk("rst_we", 64'(wb.write_enable), 64'(0));
      chk("rst_alu_ready", 64'(wb.alu_ready), 64'(1));
      chk("rst_mem_ready", 64'(wb.mem_ready), 64'(1));

      // Single ALU result appears on the write port one cycle later.
      alu(5'd3, 1'b0, 32'hDEAD_BEEF, 1'b0);
      idle(1'b0);
      chk("t1_we", 64'(wb.write_enable), 64'(1));
      chk("t1_z_addr", 64'(wb.z_regbank_addr), 64'(3));
      chk("t1_z_data", 64'(wb.z_data), 64'(32'hDEAD_BEEF));
      idle(1'b0);
      chk("t1_count", 64'(wb.count), 64'(0));

      // Both sources in one cycle: memory is older.
      step(1'b1, 5'd1, 1'b0, 32'h11, 1'b1, 5'd2, 1'b0, 32'h22, 1'b0);
      idle(1'b0);
      chk("t2_first", 64'(wb.z_regbank_addr), 64'(1));
      idle(1'b0);
      chk("t2_second", 64'(wb.z_regbank_addr), 64'(2));
      chk("t2_second_data", 64'(wb.z_data), 64'(32'h22));
      idle(1'b0);

      // Fill under stall, fifth offer refused, then in-order drain.
      for (int i = 0; i < 5; i++) alu(5'(8 + i), 1'b0, 32'(32'h100 + i), 1'b1);
      chk("t3_full_alu_ready", 64'(wb.alu_ready), 64'(0));
      chk("t3_full_count", 64'(wb.count), 64'(4));
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         chk("t3_drain_order", 64'(wb.z_regbank_addr), 64'(8 + i));
      end
      idle(1'b0);

      // Write-after-write forwarding.
      alu(5'd5, 1'b0, 32'h1, 1'b1);
      alu(5'd5, 1'b0, 32'h2, 1'b1);
      wb.a_regbank_addr = 5'd5; wb.a_regbank_sel = 1'b0;
      idle(1'b1);
      chk("t4_fwd_hit", 64'(wb.fwd_a_hit), 64'(1));
      chk("t4_fwd_data", 64'(wb.fwd_a_data), 64'(2));
      for (int i = 0; i < 3; i++) idle(1'b0);
      chk("t4_fwd_hit_after", 64'(wb.fwd_a_hit), 64'(0));
      chk("t4_regbank_r5", 64'(dut_regs_s[5]), 64'(2));

      // Predicate forwarding compares low bits and truncates data.
      alu(5'd2, 1'b1, 32'hFFFF_FFFE, 1'b1);
      wb.b_regbank_addr = 5'h1A; wb.b_regbank_sel = 1'b1;
      idle(1'b1);
      chk("t5_p_hit", 64'(wb.fwd_b_hit), 64'(1));
      chk("t5_p_data", 64'(wb.fwd_b_data), 64'(0));
      wb.b_regbank_addr = 5'd2; wb.b_regbank_sel = 1'b0;
      #1;
      chk("t5_s_miss", 64'(wb.fwd_b_hit), 64'(0));
      chk("t5_s_miss_data", 64'(wb.fwd_b_data), 64'(0));
      idle(1'b0);
      idle(1'b0);

      // Three queued, memory offered: ALU held off; then async reset mid-cycle.
      for (int i = 0; i < 3; i++) alu(5'(20 + i), 1'b0, 32'(32'hA0 + i), 1'b1);
      wb.a_regbank_addr = 5'd21;
      @(posedge clk);
      #1;
      wb.wb_stall = 1'b1;
      wb.mem_valid = 1'b1; wb.mem_addr = 5'd30; wb.mem_sel = 1'b0; wb.mem_data = 32'h5;
      wb.alu_valid = 1'b1; wb.alu_addr = 5'd31;
      #1;
      chk("t6_alu_ready", 64'(wb.alu_ready), 64'(0));
      chk("t6_mem_ready", 64'(wb.mem_ready), 64'(1));
      chk("t6_count", 64'(wb.count), 64'(3));
      chk("t6_pre_hit", 64'(wb.fwd_a_hit), 64'(1));
      wb.mem_valid = 1'b0; wb.alu_valid = 1'b0;
      #1;
      reset = 1'b0;
      sb.delete();
      #1;
      chk("t6_rst_count", 64'(wb.count), 64'(0));
      chk("t6_rst_we", 64'(wb.write_enable), 64'(0));
      chk("t6_rst_alu_ready", 64'(wb.alu_ready), 64'(1));
      chk("t6_rst_mem_ready", 64'(wb.mem_ready), 64'(1));
      chk("t6_rst_hit", 64'(wb.fwd_a_hit), 64'(0));
      @(posedge clk);
      #3;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle(1'b0);
         chk("t6_no_stale_we", 64'(wb.write_enable), 64'(0));
      end

      // Randomized traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         wb.a_regbank_addr = 5'($urandom_range(0, 7));
         wb.a_regbank_sel  = 1'($urandom_range(0, 1));
         wb.b_regbank_addr = 5'($urandom_range(0, 31));
         wb.b_regbank_sel  = 1'($urandom_range(0, 1));
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              32'($urandom),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              32'($urandom),
              1'($urandom_range(0, 3) == 0));
      end
      for (int i = 0; i < 6; i++) idle(1'b0);
      chk("final_count", 64'(wb.count), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
